fp_mul_arbiter: RTL and testbench

//  Shares one pipelined half->single FP multiplier between NUM_REQ requesters. Arbitration is round-robin.
//  The multiplier has fixed latency and no stall input, so this block carries a requester-ID tag alongside each product.
//  It routes each result back to the requester that issued it and counts operations in flight.
//  A drain/halt sequencer lets the MAC control quiesce the multiplier cleanly.

---
 rtl/fp_mul_arbiter_if.sv | 25 ++
 rtl/fp_mul_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bundle for the shared FP multiplier: operand handshake plus result return.
// Latency: none, wires only.
// Backpressure: req_ready gates operand transfer; responses have no backpressure.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_result;

    // Requesters drive operands and consume grants/results.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result
    );

    // The arbiter consumes operands and drives grants/results.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one fixed-latency half->single FP multiplier, with ID tags to route results back.
// Latency: accept in cycle t -> one-hot rsp_valid in cycle t+1+MUL_LATENCY; one accept per cycle sustained.
// Backpressure: one-hot req_ready, withheld while draining/halted; results are pushed with no backpressure.
module fp_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 5,
    parameter int ID_W        = 2
) (
    input  logic                             clock,
    input  logic                             resetn,
    fp_mul_arbiter_if.slave                  req_if,
    input  logic                             drain,
    output logic [15:0]                      mul_a,
    output logic [15:0]                      mul_b,
    input  logic [31:0]                      mul_result,
    output logic [$clog2(MUL_LATENCY+2)-1:0] inflight,
    output logic                             idle
);
    localparam int CNT_W      = $clog2(MUL_LATENCY + 2);
    // One tag stage for the operand register plus one per multiplier stage.
    localparam int TAG_STAGES = MUL_LATENCY + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TAG_STAGES);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [ID_W-1:0]    rr_ptr;

    logic [NUM_REQ-1:0] valid_rot;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic               can_grant;
    logic               accept;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;

    logic               tag_vld [TAG_STAGES];
    logic [ID_W-1:0]    tag_id  [TAG_STAGES];
    logic               rsp_fire;
    logic [ID_W-1:0]    rsp_id;

    logic [CNT_W-1:0]   inflight_nxt;

    // Rotate the request vector so bit 0 is the requester rr_ptr points at.
    assign valid_rot = NUM_REQ'({req_if.req_valid, req_if.req_valid} >> rr_ptr);

    // First valid requester at or after rr_ptr, mapped back to its absolute ID.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && valid_rot[k]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Grants only in RUN with drain low; resetn gating keeps req_ready low while reset is held.
    assign can_grant = resetn && (state == ST_RUN) && !drain;
    assign accept    = can_grant && grant_any;

    assign req_if.req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

    // Pick the granted requester's operands; unaccepted data is never captured.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_a = req_if.req_a[16*k +: 16];
                sel_b = req_if.req_b[16*k +: 16];
            end
        end
    end

    // Operand register feeding the multiplier; holds its value when nothing is accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
        end
    end

    // Round-robin pointer moves past the requester just served.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
        end
    end

    // Tag pipe shadows the multiplier: shifts every cycle since the multiplier cannot stall.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < TAG_STAGES; s++) begin
                tag_vld[s] <= 1'b0;
                tag_id[s]  <= '0;
            end
        end else begin
            tag_vld[0] <= accept;
            tag_id[0]  <= grant_id;
            for (int s = 1; s < TAG_STAGES; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    assign rsp_fire = tag_vld[TAG_STAGES-1];
    assign rsp_id   = tag_id[TAG_STAGES-1];

    assign req_if.rsp_valid  = rsp_fire ? (NUM_REQ'(1) << rsp_id) : '0;
    assign req_if.rsp_result = mul_result;

    // Occupancy: accept and response in the same cycle cancel; clamped so it can never wrap.
    always_comb begin
        inflight_nxt = inflight;
        if (accept && !rsp_fire && (inflight != CNT_MAX)) begin
            inflight_nxt = inflight + CNT_W'(1);
        end else if (!accept && rsp_fire && (inflight != '0)) begin
            inflight_nxt = inflight - CNT_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_nxt;
        end
    end

    // Drain/halt sequencing; emptiness uses the post-response count so HALT follows the last result directly.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (drain) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain) begin
                    state_nxt = ST_RUN;
                end else if (inflight_nxt == '0) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!drain) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign idle = (state == ST_HALT);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural 5-stage half->single multiplier.
// Latency: checks response timing of accept + 6 cycles.
// Backpressure: exercises grant withholding during drain/halt and reset.
module tb_fp_mul_arbiter;
    localparam int NREQ = 4;

    // Fixed operands per requester and their hand-computed single-precision products.
    localparam logic [15:0] OP_A [NREQ] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h4400};
    localparam logic [15:0] OP_B [NREQ] = '{16'h4000, 16'h3E00, 16'h4200, 16'h4200};
    localparam logic [31:0] EXP_PROD [NREQ] = '{32'h40000000, 32'h40100000, 32'hC0C00000, 32'h41400000};

    logic        clock = 1'b0;
    logic        resetn;
    logic        drain;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_result;
    logic [2:0]  inflight;
    logic        idle;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    fp_mul_arbiter_if #(.NUM_REQ(NREQ)) rif ();

    fp_mul_arbiter #(.NUM_REQ(NREQ), .MUL_LATENCY(5), .ID_W(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_if     (rif),
        .drain      (drain),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .inflight   (inflight),
        .idle       (idle)
    );

    always #5 clock = ~clock;

    // Exact product for normal half operands (the directed values need no rounding).
    function automatic logic [31:0] hmul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [7:0]  e;
        logic [7:0]  ex;
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = 8'(a[14:10]) + 8'(b[14:10]) + 8'd97;
        if (p[21]) begin
            ex = e + 8'd1;
            return {a[15] ^ b[15], ex, p[20:0], 2'b00};
        end
        ex = e;
        return {a[15] ^ b[15], ex, p[19:0], 3'b000};
    endfunction

    // Multiplier model: operands registered in cycle c produce mul_result in cycle c+5.
    logic [31:0] mp [5];
    always @(posedge clock) begin
        mp[0] <= hmul(mul_a, mul_b);
        for (int s = 1; s < 5; s++) mp[s] <= mp[s-1];
    end
    assign mul_result = mp[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of accepted operations: expected strobe/result 6 cycles after accept.
    typedef struct {
        logic [1:0] id;
        int         due;
    } sb_t;
    sb_t sb [$];

    always @(negedge clock) begin
        logic [3:0] exp_v;
        sb_t        ent;
        cyc = cyc + 1;
        if (!resetn) sb.delete();
        check("inflight_track", 32'(inflight), 32'(sb.size()));
        exp_v = '0;
        if (sb.size() > 0 && sb[0].due == cyc) exp_v = 4'b0001 << sb[0].id;
        if (exp_v != 4'b0 || rif.rsp_valid != 4'b0) begin
            check("rsp_strobe", 32'(rif.rsp_valid), 32'(exp_v));
            if (exp_v != 4'b0) begin
                check("rsp_result", rif.rsp_result, EXP_PROD[sb[0].id]);
                void'(sb.pop_front());
            end
        end
        if (resetn) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rif.req_valid[i] && rif.req_ready[i]) begin
                    ent.id  = 2'(i);
                    ent.due = cyc + 6;
                    sb.push_back(ent);
                end
            end
        end
    end

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
    } arb_vec_t;
    arb_vec_t vec [12];

    initial begin
        int lat;
        int got;
        int n_rsp;
        int last;
        int idle_at;
        int rdy_seen;

        // Sequential arbitration table starting from rr_ptr=0; each row assumes the previous rows' grants.
        vec[0]  = '{4'b0001, 4'b0001};   // ptr 0 -> req0, ptr=1
        vec[1]  = '{4'b1000, 4'b1000};   // only req3 with ptr 1 -> req3, ptr=0
        vec[2]  = '{4'b1001, 4'b0001};   // req0 ahead of req3, ptr=1
        vec[3]  = '{4'b1001, 4'b1000};   // ptr 1 scans to req3, ptr=0
        vec[4]  = '{4'b0110, 4'b0010};   // req1, ptr=2
        vec[5]  = '{4'b0110, 4'b0100};   // req2, ptr=3
        vec[6]  = '{4'b0011, 4'b0001};   // ptr 3 wraps to req0, ptr=1
        vec[7]  = '{4'b0000, 4'b0000};   // idle, ptr holds 1
        vec[8]  = '{4'b1100, 4'b0100};   // req2, ptr=3
        vec[9]  = '{4'b1111, 4'b1000};   // req3, ptr=0
        vec[10] = '{4'b1111, 4'b0001};   // req0, ptr=1
        vec[11] = '{4'b1010, 4'b0010};   // req1, ptr=2

        resetn = 1'b0;
        drain  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rif.req_a[16*i +: 16] = OP_A[i];
            rif.req_b[16*i +: 16] = OP_B[i];
        end
        rif.req_valid = 4'b1111;

        // Reset state, with every requester asking.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(rif.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rif.rsp_valid), 32'h0);
        check("rst_idle", 32'(idle), 32'h0);
        check("rst_inflight", 32'(inflight), 32'h0);
        check("rst_mul_a", 32'(mul_a), 32'h0);
        check("rst_mul_b", 32'(mul_b), 32'h0);

        // All requesters valid from reset release: grants rotate 0,1,2,3,...
        @(posedge clock); #1 resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("rr_all_valid", 32'(rif.req_ready), 32'(1) << (k % 4));
            if (k == 7) check("inflight_saturated", 32'(inflight), 32'd6);
        end
        @(posedge clock); #1 rif.req_valid = 4'b0000;
        repeat (10) @(posedge clock);

        // Arbitration table.
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1 rif.req_valid = vec[i].vld;
            @(negedge clock);
            check("arb_vec", 32'(rif.req_ready), 32'(vec[i].rdy));
        end
        @(posedge clock); #1 rif.req_valid = 4'b0000;
        repeat (10) @(posedge clock);

        // Single request from req0: latency and routing.
        #1 rif.req_valid = 4'b0001;
        @(negedge clock);
        check("single_grant", 32'(rif.req_ready), 32'h1);
        @(posedge clock); #1 rif.req_valid = 4'b0000;
        lat = 1;
        got = 0;
        while (lat < 20 && got == 0) begin
            @(negedge clock);
            if (rif.rsp_valid != 4'b0) got = 1;
            else lat++;
        end
        check("single_latency", 32'(lat), 32'd6);
        check("single_strobe", 32'(rif.rsp_valid), 32'h1);
        check("single_result", rif.rsp_result, 32'h40000000);
        repeat (4) @(posedge clock);

        // Fill six in flight (rr_ptr=1 -> 1,2,3,0,1,2), then drain.
        @(posedge clock); #1 rif.req_valid = 4'b1111;
        repeat (6) @(posedge clock);
        #1 drain = 1'b1;
        n_rsp    = 0;
        last     = -1;
        idle_at  = -1;
        rdy_seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (k == 0) check("drain_start_inflight", 32'(inflight), 32'd6);
            if (rif.rsp_valid != 4'b0) begin
                n_rsp++;
                last = k;
            end
            if (idle && idle_at < 0) idle_at = k;
            if (rif.req_ready != 4'b0) rdy_seen++;
        end
        check("drain_rsp_count", 32'(n_rsp), 32'd6);
        check("drain_last_rsp", 32'(last), 32'd5);
        check("drain_idle_cycle", 32'(idle_at), 32'd6);
        check("drain_no_grant", 32'(rdy_seen), 32'd0);
        check("halt_inflight", 32'(inflight), 32'd0);
        @(posedge clock); #1 drain = 1'b0;
        @(negedge clock);
        check("halt_exit_idle", 32'(idle), 32'h1);
        check("halt_exit_ready", 32'(rif.req_ready), 32'h0);
        @(negedge clock);
        check("resume_idle", 32'(idle), 32'h0);
        check("resume_grant", 32'(rif.req_ready), 32'h8);
        @(posedge clock); #1 rif.req_valid = 4'b0000;
        repeat (8) @(posedge clock);

        // Reset with four operations in flight.
        #1 rif.req_valid = 4'b1111;
        repeat (4) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("midrst_req_ready", 32'(rif.req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(rif.rsp_valid), 32'h0);
        check("midrst_inflight", 32'(inflight), 32'h0);
        check("midrst_idle", 32'(idle), 32'h0);
        check("midrst_mul_a", 32'(mul_a), 32'h0);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        rif.req_valid = 4'b0000;
        n_rsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (rif.rsp_valid != 4'b0) n_rsp++;
        end
        check("midrst_no_rsp", 32'(n_rsp), 32'd0);
        check("midrst_inflight_after", 32'(inflight), 32'd0);

        // drain held through reset release: RUN, DRAIN, HALT.
        @(posedge clock); #1 resetn = 1'b0;
        drain = 1'b1;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("rel_drain_c0_idle", 32'(idle), 32'h0);
        @(negedge clock);
        check("rel_drain_c1_idle", 32'(idle), 32'h0);
        @(negedge clock);
        check("rel_drain_c2_idle", 32'(idle), 32'h1);
        @(posedge clock); #1 drain = 1'b0;
        repeat (3) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
